// File: rtl/lsu_pkg.sv
// Shared definitions for the MEM-stage load/store port: access-size
// encodings, controller state encoding and byte-lane select masks.
package lsu_pkg;

  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_RMW_WR = 1'b1
  } lsu_state_e;

  // Lane masks for an access sitting at byte offset 0; shift by the offset.
  localparam logic [3:0] LANE_B = 4'b0001;
  localparam logic [3:0] LANE_H = 4'b0011;
  localparam logic [3:0] LANE_W = 4'b1111;

endpackage

// File: rtl/lsu_lane_align.sv
// Byte-lane alignment for the load/store port (little-endian lanes).
// Loads: pull the addressed byte/half down to bit 0 and sign/zero extend.
// Stores: merge the right-aligned store data into the old word's lanes.
module lsu_lane_align
  import lsu_pkg::*;
(
  input  logic [1:0]  size_i,
  input  logic        unsigned_i,
  input  logic [1:0]  offset_i,
  input  logic [31:0] old_word_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] load_data_o,
  output logic [31:0] merged_o
);

  logic [31:0] shifted_s;
  logic [31:0] wdata_sh_s;
  logic [3:0]  lane_mask_s;

  // Load extract: shift the addressed lane(s) to the bottom, then extend.
  always_comb begin
    shifted_s = old_word_i >> {offset_i, 3'b000};
    case (size_i)
      SZ_B:    load_data_o = {{24{shifted_s[7] & ~unsigned_i}}, shifted_s[7:0]};
      SZ_H:    load_data_o = {{16{shifted_s[15] & ~unsigned_i}}, shifted_s[15:0]};
      default: load_data_o = old_word_i;
    endcase
  end

  // Store merge: replace only the target lanes of the old word.
  always_comb begin
    case (size_i)
      SZ_B:    lane_mask_s = LANE_B << offset_i;
      SZ_H:    lane_mask_s = LANE_H << offset_i;
      default: lane_mask_s = LANE_W;
    endcase
    wdata_sh_s = wdata_i << {offset_i, 3'b000};
    merged_o   = old_word_i;
    for (int k = 0; k < 4; k++) begin
      if (lane_mask_s[k]) begin
        merged_o[8*k +: 8] = wdata_sh_s[8*k +: 8];
      end else begin
        merged_o[8*k +: 8] = old_word_i[8*k +: 8];
      end
    end
  end

endmodule

// File: rtl/lsu_mem_port.sv
// MEM-stage load/store initiator for a word-addressed data memory with
// combinational read and clocked write. Sub-word stores are done as a
// read-modify-write over two cycles, stalling the pipeline via req_ready.
// Build option: define LSU_SUBWORD_EN for byte/half accesses; without it
// every access is a word access and the RMW path is absent.
module lsu_mem_port
  import lsu_pkg::*;
#(
  parameter int DEPTH = 32,
  parameter int TAG_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             req_we,
  input  logic [1:0]       req_size,
  input  logic             req_unsigned,
  input  logic [31:0]      req_addr,
  input  logic [31:0]      req_wdata,
  input  logic [TAG_W-1:0] req_tag,
  output logic             resp_valid,
  output logic [31:0]      resp_rdata,
  output logic [TAG_W-1:0] resp_tag,
  output logic             resp_fault,
  output logic [31:0]      mem_address,
  output logic [31:0]      mem_data_in,
  output logic             mem_we,
  output logic             mem_read,
  input  logic [31:0]      mem_data_out
);

  localparam int AW = $clog2(DEPTH);

  lsu_state_e       state_q, state_d;
  logic             resp_valid_q, resp_valid_d;
  logic [31:0]      resp_rdata_q, resp_rdata_d;
  logic [TAG_W-1:0] resp_tag_q, resp_tag_d;
  logic             resp_fault_q, resp_fault_d;
  logic [31:0]      merged_q, merged_d;
  logic [AW-1:0]    addr_q, addr_d;
  logic [TAG_W-1:0] tag_q, tag_d;

  logic        accept_s;
  logic        range_fault_s;
  logic        fault_s;
  logic        is_word_s;
  logic [31:0] load_data_s;
  logic [31:0] merged_s;
  logic        mem_we_s;
  logic        mem_read_s;

  assign req_ready     = (state_q == ST_IDLE) && !rst;
  assign accept_s      = req_valid && req_ready;
  assign range_fault_s = (req_addr[31:2] >= 30'(DEPTH));

`ifdef LSU_SUBWORD_EN
  assign is_word_s = (req_size == SZ_W);

  // Alignment and size faults; bytes can never be misaligned.
  always_comb begin
    case (req_size)
      SZ_B:    fault_s = range_fault_s;
      SZ_H:    fault_s = range_fault_s | req_addr[0];
      SZ_W:    fault_s = range_fault_s | (req_addr[1:0] != 2'b00);
      default: fault_s = 1'b1;
    endcase
  end

  lsu_lane_align u_lane_align (
    .size_i      (req_size),
    .unsigned_i  (req_unsigned),
    .offset_i    (req_addr[1:0]),
    .old_word_i  (mem_data_out),
    .wdata_i     (req_wdata),
    .load_data_o (load_data_s),
    .merged_o    (merged_s)
  );
`else
  // Size and signedness have no meaning in the word-only build.
  logic unused_cfg_s;
  assign unused_cfg_s = ^{req_size, req_unsigned};
  assign is_word_s    = 1'b1;
  assign fault_s      = range_fault_s | (req_addr[1:0] != 2'b00);
  assign load_data_s  = mem_data_out;
  assign merged_s     = 32'h0000_0000;
`endif

  // Next state, memory-port drive and response capture.
  always_comb begin
    state_d      = state_q;
    resp_valid_d = 1'b0;
    resp_rdata_d = 32'h0000_0000;
    resp_tag_d   = {TAG_W{1'b0}};
    resp_fault_d = 1'b0;
    merged_d     = merged_q;
    addr_d       = addr_q;
    tag_d        = tag_q;
    mem_address  = 32'h0000_0000;
    mem_data_in  = 32'h0000_0000;
    mem_we_s     = 1'b0;
    mem_read_s   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!accept_s) begin
          state_d = ST_IDLE;
        end else if (fault_s) begin
          resp_valid_d = 1'b1;
          resp_fault_d = 1'b1;
          resp_tag_d   = req_tag;
        end else if (!req_we) begin
          mem_address  = {2'b00, req_addr[31:2]};
          mem_read_s   = 1'b1;
          resp_valid_d = 1'b1;
          resp_rdata_d = load_data_s;
          resp_tag_d   = req_tag;
        end else if (is_word_s) begin
          mem_address  = {2'b00, req_addr[31:2]};
          mem_data_in  = req_wdata;
          mem_we_s     = 1'b1;
          resp_valid_d = 1'b1;
          resp_tag_d   = req_tag;
        end else begin
          mem_address = {2'b00, req_addr[31:2]};
          mem_read_s  = 1'b1;
          merged_d    = merged_s;
          addr_d      = req_addr[AW+1:2];
          tag_d       = req_tag;
          state_d     = ST_RMW_WR;
        end
      end
      ST_RMW_WR: begin
        mem_address  = {{(32-AW){1'b0}}, addr_q};
        mem_data_in  = merged_q;
        mem_we_s     = 1'b1;
        resp_valid_d = 1'b1;
        resp_tag_d   = tag_q;
        state_d      = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Reset suppresses any memory strobe, including a pending RMW write.
  assign mem_we   = mem_we_s & ~rst;
  assign mem_read = mem_read_s & ~rst;

  // State, RMW holding and response registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= 32'h0000_0000;
      resp_tag_q   <= {TAG_W{1'b0}};
      resp_fault_q <= 1'b0;
      merged_q     <= 32'h0000_0000;
      addr_q       <= {AW{1'b0}};
      tag_q        <= {TAG_W{1'b0}};
    end else begin
      state_q      <= state_d;
      resp_valid_q <= resp_valid_d;
      resp_rdata_q <= resp_rdata_d;
      resp_tag_q   <= resp_tag_d;
      resp_fault_q <= resp_fault_d;
      merged_q     <= merged_d;
      addr_q       <= addr_d;
      tag_q        <= tag_d;
    end
  end

  assign resp_valid = resp_valid_q;
  assign resp_rdata = resp_rdata_q;
  assign resp_tag   = resp_tag_q;
  assign resp_fault = resp_fault_q;

endmodule

// File: tb/tb_lsu_mem_port.sv
// Bench for lsu_mem_port: a behavioural data memory, a byte-level reference
// model of memory contents and load results, directed cases and a random
// mix of loads/stores. Honours LSU_SUBWORD_EN like the design.
module tb_lsu_mem_port;
  import lsu_pkg::*;

  localparam int DEPTH = 32;
  localparam int TAG_W = 5;
  localparam int AW    = $clog2(DEPTH);

  logic             clk = 1'b0;
  logic             rst;
  logic             req_valid;
  logic             req_ready;
  logic             req_we;
  logic [1:0]       req_size;
  logic             req_unsigned;
  logic [31:0]      req_addr;
  logic [31:0]      req_wdata;
  logic [TAG_W-1:0] req_tag;
  logic             resp_valid;
  logic [31:0]      resp_rdata;
  logic [TAG_W-1:0] resp_tag;
  logic             resp_fault;
  logic [31:0]      mem_address;
  logic [31:0]      mem_data_in;
  logic             mem_we;
  logic             mem_read;
  logic [31:0]      mem_data_out;

  logic [31:0] mem_arr [DEPTH];
  logic [31:0] exp_mem [DEPTH];
  int n_vec = 0;
  int n_err = 0;

  lsu_mem_port #(.DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_we(req_we), .req_size(req_size), .req_unsigned(req_unsigned),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_tag(req_tag),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_tag(resp_tag),
    .resp_fault(resp_fault), .mem_address(mem_address), .mem_data_in(mem_data_in),
    .mem_we(mem_we), .mem_read(mem_read), .mem_data_out(mem_data_out)
  );

  always #5 clk = ~clk;

  // Data memory: combinational read, write on the rising edge.
  always @(posedge clk) begin
    if (mem_we && (mem_address < DEPTH)) mem_arr[mem_address[AW-1:0]] <= mem_data_in;
  end
  assign mem_data_out = (mem_address < DEPTH) ? mem_arr[mem_address[AW-1:0]] : 32'hDEAD_DEAD;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  // Reference model: computes outcome from byte-level rules, updates exp_mem.
  task automatic model(input logic we, input logic [1:0] size, input logic uns,
                       input logic [31:0] addr, input logic [31:0] wdata,
                       output logic fault, output logic [31:0] rdata, output int lat);
    logic [1:0]  sz;
    logic [31:0] word;
    int unsigned idx, off, nb;
`ifdef LSU_SUBWORD_EN
    sz = size;
`else
    sz = 2'd2;
`endif
    idx   = addr >> 2;
    off   = addr % 4;
    fault = (idx >= DEPTH) || (sz == 2'd3) || (sz == 2'd1 && off % 2 != 0) ||
            (sz == 2'd2 && off != 0);
    rdata = 32'd0;
    lat   = 1;
    if (!fault) begin
      nb   = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
      word = exp_mem[idx];
      if (!we) begin
        for (int i = 0; i < nb; i++) rdata[8*i +: 8] = word[8*(off+i) +: 8];
        if (!uns && rdata[8*nb-1]) for (int i = nb; i < 4; i++) rdata[8*i +: 8] = 8'hFF;
      end else begin
        for (int i = 0; i < nb; i++) word[8*(off+i) +: 8] = wdata[8*i +: 8];
        exp_mem[idx] = word;
        if (nb < 4) lat = 2;
      end
    end
  endtask

  // Issue one request and check port strobes, latency and response.
  task automatic issue(input logic we, input logic [1:0] size, input logic uns,
                       input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [TAG_W-1:0] tag);
    logic        e_fault;
    logic [31:0] e_rdata;
    int          lat;
    int          budget = 0;
    while (!req_ready && budget < 8) begin
      @(posedge clk); #1;
      budget++;
    end
    check_val("req_ready_wait", {31'd0, req_ready}, 32'd1);
    model(we, size, uns, addr, wdata, e_fault, e_rdata, lat);
    req_we = we; req_size = size; req_unsigned = uns; req_addr = addr;
    req_wdata = wdata; req_tag = tag; req_valid = 1'b1;
    #1;
    check_val("mem_read", {31'd0, mem_read}, {31'd0, !e_fault && (!we || lat == 2)});
    check_val("mem_we", {31'd0, mem_we}, {31'd0, !e_fault && we && lat == 1});
    if (!e_fault) check_val("mem_address", mem_address, addr >> 2);
    @(posedge clk); #1;
    req_valid = 1'b0;
    if (lat == 2) begin
      check_val("rmw_ready_low", {31'd0, req_ready}, 32'd0);
      check_val("rmw_no_resp", {31'd0, resp_valid}, 32'd0);
      check_val("rmw_mem_we", {31'd0, mem_we}, 32'd1);
      check_val("rmw_address", mem_address, addr >> 2);
      check_val("rmw_data", mem_data_in, exp_mem[addr >> 2]);
      @(posedge clk); #1;
    end
    check_val("resp_valid", {31'd0, resp_valid}, 32'd1);
    check_val("resp_rdata", resp_rdata, e_rdata);
    check_val("resp_tag", {27'd0, resp_tag}, {27'd0, tag});
    check_val("resp_fault", {31'd0, resp_fault}, {31'd0, e_fault});
  endtask

  task automatic check_all_zero(input string tag);
    check_val({tag, "_valid"}, {31'd0, resp_valid}, 32'd0);
    check_val({tag, "_rdata"}, resp_rdata, 32'd0);
    check_val({tag, "_tag"}, {27'd0, resp_tag}, 32'd0);
    check_val({tag, "_fault"}, {31'd0, resp_fault}, 32'd0);
    check_val({tag, "_mem_we"}, {31'd0, mem_we}, 32'd0);
    check_val({tag, "_mem_read"}, {31'd0, mem_read}, 32'd0);
    check_val({tag, "_mem_addr"}, mem_address, 32'd0);
  endtask

  initial begin
    rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_size = 2'd0; req_unsigned = 1'b0;
    req_addr = 32'd0; req_wdata = 32'd0; req_tag = '0;
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");
    check_val("reset_ready", {31'd0, req_ready}, 32'd0);
    rst = 1'b0;
    #1;
    check_val("ready_after_reset", {31'd0, req_ready}, 32'd1);

    // Fill memory through the port with word stores.
    for (int i = 0; i < DEPTH; i++) issue(1'b1, SZ_W, 1'b0, 32'(i * 4), $urandom, 5'(i));

`ifdef LSU_SUBWORD_EN
    issue(1'b1, SZ_W, 1'b0, 32'h4, 32'h8000_00F0, 5'd1);
    issue(1'b1, SZ_W, 1'b0, 32'h8, 32'h1122_3344, 5'd2);
    issue(1'b1, SZ_W, 1'b0, 32'hC, 32'h0000_0000, 5'd3);
    issue(1'b0, SZ_B, 1'b0, 32'h4, 32'h0, 5'd7);
    issue(1'b0, SZ_H, 1'b1, 32'h6, 32'h0, 5'd8);
    issue(1'b0, SZ_H, 1'b0, 32'h6, 32'h0, 5'd9);
    issue(1'b1, SZ_B, 1'b0, 32'h9, 32'h0000_00AA, 5'd10);
    check_val("byte_store_word2", mem_arr[2], 32'h1122_AA44);
    issue(1'b1, SZ_H, 1'b0, 32'hC, 32'h0000_BEEF, 5'd11);
    issue(1'b0, SZ_W, 1'b0, 32'hC, 32'h0, 5'd12);
    check_val("half_store_word3", mem_arr[3], 32'h0000_BEEF);
    issue(1'b0, 2'b11, 1'b0, 32'h10, 32'h0, 5'd13);
    issue(1'b0, SZ_H, 1'b0, 32'h11, 32'h0, 5'd14);

    // Reset while the RMW write is pending: the write must be dropped.
    req_we = 1'b1; req_size = SZ_B; req_unsigned = 1'b0; req_addr = 32'h11;
    req_wdata = 32'h55; req_tag = 5'd15; req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    rst = 1'b1;
    #1;
    check_val("rst_rmw_mem_we", {31'd0, mem_we}, 32'd0);
    @(posedge clk); #1;
    check_all_zero("rst_rmw");
    check_val("rst_rmw_word4", mem_arr[4], exp_mem[4]);
    rst = 1'b0;
    #1;
    check_val("rst_rmw_ready", {31'd0, req_ready}, 32'd1);
`else
    issue(1'b1, SZ_W, 1'b0, 32'hC, 32'h0000_BEEF, 5'd11);
    issue(1'b0, SZ_W, 1'b0, 32'hC, 32'h0, 5'd12);
    check_val("word_store_word3", mem_arr[3], 32'h0000_BEEF);
    issue(1'b0, SZ_B, 1'b0, 32'h5, 32'h0, 5'd13);
`endif
    issue(1'b1, SZ_W, 1'b0, 32'h2, 32'hDEAD_BEEF, 5'd4);
    issue(1'b0, SZ_W, 1'b0, 32'h80, 32'h0, 5'd5);
    issue(1'b1, SZ_W, 1'b0, 32'hFFFF_FFFC, 32'h1234_5678, 5'd6);

    // Random mix, with occasional idle cycles to check single-cycle pulses.
    for (int n = 0; n < 400; n++) begin
      logic [31:0] a;
      if ($urandom_range(0, 9) == 0) a = $urandom;
      else a = 32'($urandom_range(0, DEPTH * 4 + 3));
      issue(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
            a, $urandom, 5'($urandom_range(0, 31)));
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clk); #1;
        check_val("resp_pulse_end", {31'd0, resp_valid}, 32'd0);
      end
    end

    // Final sweep: memory contents and word loads against the model.
    for (int i = 0; i < DEPTH; i++) check_val("mem_final", mem_arr[i], exp_mem[i]);
    for (int i = 0; i < DEPTH; i++) issue(1'b0, SZ_W, 1'b0, 32'(i * 4), 32'd0, 5'(i));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/lsu_mem_port.md
# lsu_mem_port

Load/store initiator for the data memory in the MEM stage of the pipelined core. Accepts one load or store per handshake from the EX/MEM register, drives the word-addressed data-memory port (combinational read, write on clock edge), performs byte/half extraction with sign/zero extension, and performs read-modify-write for sub-word stores. Returns a registered response (load data, destination tag, fault) to the MEM/WB register, and deasserts `req_ready` to stall the pipeline during multi-cycle stores.

## Interface
- `DEPTH`, 32: memory depth in 32-bit words; word index width is clog2(DEPTH)
- `TAG_W`, 5: width of the destination-register tag
- `clk` in 1: the single clock
- `rst` in 1: synchronous, active-high reset
- `req_valid` in 1: request present
- `req_ready` out 1: block can accept; transfer when both high at a rising edge
- `req_we` in 1: 1 = store, 0 = load
- `req_size` in 2: 00 byte, 01 half, 10 word, 11 reserved
- `req_unsigned` in 1: load zero-extends when 1, sign-extends when 0
- `req_addr` in 32: byte address
- `req_wdata` in 32: store data, right-aligned
- `req_tag` in TAG_W: destination tag, returned unchanged
- `resp_valid` out 1: one-cycle response pulse
- `resp_rdata` out 32: extended load data; 0 for stores and faults
- `resp_tag` out TAG_W: tag of the completed request
- `resp_fault` out 1: misaligned, reserved-size or out-of-range access
- `mem_address` out 32: word index (req_addr >> 2), zero-extended
- `mem_data_in` out 32: write data to memory
- `mem_we` out 1: memory write enable
- `mem_read` out 1: memory read enable
- `mem_data_out` in 32: combinational read data from memory

## Operation
- States: IDLE, RMW_WR. `req_ready` = (state == IDLE) && !rst.
- Byte lanes little-endian: lane k = bits [8k+7:8k], k = req_addr[1:0]; half uses lanes {k+1,k}.
- Fault when: size 11; half with addr[0]=1; word with addr[1:0]!=0; (addr >> 2) >= DEPTH. A faulting request raises neither `mem_read` nor `mem_we`, completes in one cycle, and returns fault=1, rdata=0.
- Load (accept in IDLE): `mem_read`=1 that cycle; extracted/extended data registered into `resp_rdata`; state stays IDLE.
- Word store: `mem_we`=1 and `mem_data_in`=req_wdata in the accept cycle; state stays IDLE.
- Sub-word store: accept cycle drives `mem_read`=1, registers the merged word (old word with target lanes replaced by req_wdata low bits), address and tag; -> RMW_WR. In RMW_WR, `mem_we`=1 with the merged word at the held address; -> IDLE.
- In IDLE with no transfer, all `mem_*` outputs are 0.

## Timing
- Reset: state IDLE; `resp_valid`, `resp_rdata`, `resp_tag`, `resp_fault` = 0; `mem_we`, `mem_read` gated to 0 while `rst` is high. Reset in RMW_WR discards the pending write.
- Load/word store/fault: accept at edge N -> `resp_valid` high in cycle N+1. Throughput 1 per cycle.
- Sub-word store: accept at N -> write at edge N+1 -> `resp_valid` in N+2. `req_ready` low during N+1. Throughput 1 per 2 cycles.
- `resp_valid` is high for exactly one cycle per accepted request, with no backpressure. A back-to-back load after a sub-word store reads the updated word.

## Configuration
- `LSU_SUBWORD_EN` defined: behaviour as above.
- Not defined: `req_size` and `req_unsigned` ignored; every access is a word access; RMW_WR and lane logic are removed; fault is raised only for addr[1:0]!=0 or out-of-range.

## Structure
- `lsu_pkg`: size encodings (SZ_B, SZ_H, SZ_W), state enum, lane-select helper constants.
- One sub-module, `lsu_lane_align`: combinational load extract/extend and store merge from (size, unsigned, addr[1:0]).

## Test plan
- Word 1 = 0x8000_00F0; load byte, addr 0x4, signed -> rdata 0xFFFF_FFF0, tag echoed, `resp_valid` in the next cycle.
- Same word; load half, addr 0x6, unsigned -> 0x0000_8000; signed -> 0xFFFF_8000.
- Word 2 = 0x1122_3344; store byte 0xAA at addr 0x9 -> `req_ready` low for one cycle, word 2 = 0x1122_AA44, `resp_valid` two cycles after accept.
- Store word 0xDEAD_BEEF at addr 0x2 -> fault=1, rdata 0, `mem_we` never high; load word at addr 0x80 (DEPTH 32) -> fault=1.
- Back-to-back: store half 0xBEEF at addr 0xC (word 3 = 0) then load word at 0xC -> 0x0000_BEEF.
- Assert `rst` during RMW_WR -> no write occurs, all outputs 0 on the next cycle, `req_ready` high after reset is released.
